// File: rtl/key_expansion_ctrl.sv
// ============================================================================
//  Module   : key_expansion_ctrl
//  Purpose  : Steps one AES-128 key-schedule unit through rounds 1..NR and
//             holds the cipher key plus all round keys in a registered-read key file.
//  Options  : KEY_EXP_TIMEOUT_EN - abort a round with a sticky err flag when
//             ks_done does not arrive within TIMEOUT_CYCLES.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_expansion_ctrl #(
    parameter int NR             = 10,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key_in,
    input  logic         key_load,
    output logic         busy,
    output logic         keys_valid,
    output logic [127:0] ks_in,
    output logic [3:0]   ks_round,
    output logic         ks_ready,
    input  logic [127:0] ks_out,
    input  logic         ks_done,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data,
    output logic         err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] LAST_RND = 4'(NR);

    // Key file is deliberately not reset; keys_valid qualifies its contents.
    logic [127:0] rk_mem [0:NR];

    logic [1:0]   state_q, state_d;
    logic [127:0] cur_q, cur_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         keys_valid_q, keys_valid_d;
    logic [127:0] rk_data_q, rk_data_d;

    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [127:0] wr_data;

`ifdef KEY_EXP_TIMEOUT_EN
    localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        rnd_d        = rnd_q;
        keys_valid_d = keys_valid_q;
        wr_en        = 1'b0;
        wr_addr      = rnd_q;
        wr_data      = ks_out;
`ifdef KEY_EXP_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (key_load) begin
                    wr_en        = 1'b1;
                    wr_addr      = 4'd0;
                    wr_data      = key_in;
                    cur_d        = key_in;
                    rnd_d        = 4'd1;
                    keys_valid_d = 1'b0;
                    state_d      = S_ISSUE;
`ifdef KEY_EXP_TIMEOUT_EN
                    err_d        = 1'b0;
`endif
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef KEY_EXP_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                if (ks_done) begin
                    wr_en = 1'b1;
                    cur_d = ks_out;
                    if (rnd_q == LAST_RND) begin
                        state_d = S_DONE;
                    end else begin
                        rnd_d   = rnd_q + 4'd1;
                        state_d = S_ISSUE;
                    end
                end
`ifdef KEY_EXP_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_DONE: begin
                keys_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Out-of-range addresses read as zero rather than aliasing into the file.
    always_comb begin
        rk_data_d = '0;
        if (rk_addr <= LAST_RND) begin
            rk_data_d = rk_mem[rk_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cur_q        <= '0;
            rnd_q        <= '0;
            keys_valid_q <= 1'b0;
            rk_data_q    <= '0;
`ifdef KEY_EXP_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            rnd_q        <= rnd_d;
            keys_valid_q <= keys_valid_d;
            rk_data_q    <= rk_data_d;
`ifdef KEY_EXP_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            rk_mem[wr_addr] <= wr_data;
        end
    end

    assign busy       = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign ks_ready   = (state_q == S_ISSUE);
    assign ks_in      = cur_q;
    assign ks_round   = rnd_q;
    assign keys_valid = keys_valid_q;
    assign rk_data    = rk_data_q;
`ifdef KEY_EXP_TIMEOUT_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_key_expansion_ctrl.sv
// ============================================================================
//  Module   : tb_key_expansion_ctrl
//  Purpose  : Scoreboard bench for key_expansion_ctrl with a behavioural
//             AES-128 key-schedule unit of programmable latency.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_expansion_ctrl;

    localparam logic [127:0] KEY_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_SEQ   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] SEQ_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] key_in;
    logic         key_load;
    logic         busy;
    logic         keys_valid;
    logic [127:0] ks_in;
    logic [3:0]   ks_round;
    logic         ks_ready;
    logic [127:0] ks_out;
    logic         ks_done;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic         err;

    logic         model_done;
    logic         spur_done;
    logic         rd_req;
    logic         rd_req_d;
    int           lat_cfg;
    bit           unit_mute;
    int           cyc = 0;

    int n_checks = 0;
    int n_errs   = 0;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] kin;
        int           gap;
    } iss_t;

    iss_t         exp_iss[$];
    logic [127:0] exp_rd[$];
    logic [127:0] erk [0:10];

    assign ks_done = model_done | spur_done;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rd_req_d <= rd_req;

    key_expansion_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .key_in     (key_in),
        .key_load   (key_load),
        .busy       (busy),
        .keys_valid (keys_valid),
        .ks_in      (ks_in),
        .ks_round   (ks_round),
        .ks_ready   (ks_ready),
        .ks_out     (ks_out),
        .ks_done    (ks_done),
        .rk_addr    (rk_addr),
        .rk_data    (rk_data),
        .err        (err)
    );

    // ---------------- AES-128 key-schedule reference ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv  = 8'h01;
        logic [7:0] base = a;
        logic [7:0] e    = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) inv = gmul(inv, base);
            base = gmul(base, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] ks_next(input logic [127:0] k, input logic [3:0] r);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc = 8'h01;
        {w0, w1, w2, w3} = k;
        for (int i = 1; i < int'(r); i++) rc = xtime(rc);
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural unit: ks_done asserted in the L-th cycle after the ISSUE cycle.
    initial begin
        logic [127:0] in_k;
        logic [3:0]   in_r;
        bit           ab;
        model_done = 1'b0;
        ks_out     = '0;
        @(negedge clk);
        forever begin
            if (ks_ready === 1'b1 && reset === 1'b0) begin
                in_k = ks_in;
                in_r = ks_round;
                ab   = 1'b0;
                for (int i = 0; i < lat_cfg; i++) begin
                    @(negedge clk);
                    if (reset) ab = 1'b1;
                end
                if (!ab && !unit_mute) begin
                    model_done = 1'b1;
                    ks_out     = ks_next(in_k, in_r);
                    @(negedge clk);
                    model_done = 1'b0;
                end
            end else begin
                @(negedge clk);
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT issues a round or returns read data.
    initial begin
        iss_t cur_exp;
        int   last_cyc = 0;
        cur_exp = '{rnd: 4'd0, kin: '0, gap: 0};
        forever begin
            @(negedge clk);
            if (reset === 1'b0) begin
                if (ks_ready === 1'b1) begin
                    if (exp_iss.size() == 0) begin
                        chk("unexpected_issue", {124'd0, ks_round}, 128'd0);
                    end else begin
                        cur_exp = exp_iss.pop_front();
                        chk("issue_round", {124'd0, ks_round}, {124'd0, cur_exp.rnd});
                        chk("issue_ks_in", ks_in, cur_exp.kin);
                        if (cur_exp.gap > 0) chk("issue_spacing", cyc - last_cyc, cur_exp.gap);
                        last_cyc = cyc;
                    end
                end else if (busy === 1'b1) begin
                    chk("wait_round_held", {124'd0, ks_round}, {124'd0, cur_exp.rnd});
                    chk("wait_ks_in_held", ks_in, cur_exp.kin);
                end
                if (rd_req_d === 1'b1) begin
                    if (exp_rd.size() == 0) chk("unexpected_read", rk_data, 128'd0);
                    else                    chk("rk_data", rk_data, exp_rd.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy",       {127'd0, busy},       128'd0);
        chk("rst_keys_valid", {127'd0, keys_valid}, 128'd0);
        chk("rst_ks_ready",   {127'd0, ks_ready},   128'd0);
        chk("rst_ks_round",   {124'd0, ks_round},   128'd0);
        chk("rst_ks_in",      ks_in,                128'd0);
        chk("rst_rk_data",    rk_data,              128'd0);
        chk("rst_err",        {127'd0, err},        128'd0);
    endtask

    task automatic start_load(input logic [127:0] key, input int lat);
        iss_t it;
        cycle();
        lat_cfg  = lat;
        key_in   = key;
        key_load = 1'b1;
        erk[0]   = key;
        for (int r = 1; r <= 10; r++) erk[r] = ks_next(erk[r-1], 4'(r));
        for (int r = 1; r <= 10; r++) begin
            it = '{rnd: 4'(r), kin: erk[r-1], gap: (r == 1) ? 0 : 1 + lat};
            exp_iss.push_back(it);
        end
        cycle();
        key_load = 1'b0;
        chk("load_busy",       {127'd0, busy},       128'd1);
        chk("load_keys_valid", {127'd0, keys_valid}, 128'd0);
        chk("load_err",        {127'd0, err},        128'd0);
    endtask

    task automatic wait_done();
        int n = 0;
        while (keys_valid !== 1'b1 && n < 400) begin
            cycle();
            n++;
        end
        chk("done_keys_valid", {127'd0, keys_valid}, 128'd1);
        chk("done_busy",       {127'd0, busy},       128'd0);
    endtask

    task automatic wait_round(input logic [3:0] r, input bit need_issue);
        int n = 0;
        while (!(busy === 1'b1 && ks_round === r && (!need_issue || ks_ready === 1'b1)) && n < 400) begin
            cycle();
            n++;
        end
        chk("reached_round", {124'd0, ks_round}, {124'd0, r});
    endtask

    task automatic rd(input logic [3:0] a, input logic [127:0] e);
        rk_addr = a;
        rd_req  = 1'b1;
        exp_rd.push_back(e);
        cycle();
    endtask

    task automatic verify_all(input logic [127:0] rk10_exp);
        for (int a = 0; a < 10; a++) rd(4'(a), erk[a]);
        rd(4'd10, rk10_exp);
        rd(4'd11, 128'd0);
        rd(4'd15, 128'd0);
        rd_req = 1'b0;
        cycle();
        cycle();
    endtask

    initial begin
        reset      = 1'b1;
        key_in     = '0;
        key_load   = 1'b0;
        rk_addr    = '0;
        rd_req     = 1'b0;
        spur_done  = 1'b0;
        lat_cfg    = 3;
        unit_mute  = 1'b0;
        repeat (3) cycle();
        chk_reset_vals();
        reset = 1'b0;

        // Cipher key from the AES reference, unit latency 3.
        start_load(KEY_FIPS, 3);
        wait_done();
        rd(4'd1, FIPS_RK1);
        verify_all(FIPS_RK10);

        // Same key at latencies 1 and 7; reload while keys_valid=1.
        start_load(KEY_FIPS, 1);
        wait_done();
        verify_all(FIPS_RK10);
        start_load(KEY_FIPS, 7);
        wait_done();
        verify_all(FIPS_RK10);

        // key_load mid-expansion is ignored.
        start_load(KEY_FIPS, 3);
        wait_round(4'd5, 1'b0);
        key_in   = '0;
        key_load = 1'b1;
        cycle();
        key_load = 1'b0;
        chk("ignored_load_busy", {127'd0, busy}, 128'd1);
        wait_done();
        verify_all(FIPS_RK10);

        // Reset at round 4, stale ks_done, then a fresh key.
        start_load(KEY_FIPS, 3);
        wait_round(4'd4, 1'b1);
        reset = 1'b1;
        cycle();
        chk_reset_vals();
        reset = 1'b0;
        exp_iss.delete();
        spur_done = 1'b1;
        cycle();
        spur_done = 1'b0;
        chk("spur_busy",     {127'd0, busy},     128'd0);
        chk("spur_ks_ready", {127'd0, ks_ready}, 128'd0);
        start_load(KEY_SEQ, 3);
        wait_done();
        verify_all(SEQ_RK10);

`ifdef KEY_EXP_TIMEOUT_EN
        begin
            int n = 0;
            unit_mute = 1'b1;
            start_load(KEY_FIPS, 3);
            while (err !== 1'b1 && n < 60) begin
                cycle();
                n++;
            end
            chk("timeout_edges",  n,                    128'd17);
            chk("timeout_err",    {127'd0, err},        128'd1);
            chk("timeout_busy",   {127'd0, busy},       128'd0);
            chk("timeout_valid",  {127'd0, keys_valid}, 128'd0);
            repeat (3) cycle();
            chk("err_sticky",     {127'd0, err},        128'd1);
            exp_iss.delete();
            unit_mute = 1'b0;
            start_load(KEY_FIPS, 2);
            wait_done();
            verify_all(FIPS_RK10);
        end
`endif

        chk("issue_queue_drained", exp_iss.size(), 128'd0);
        chk("read_queue_drained",  exp_rd.size(),  128'd0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
